text_pixel_fetcher_vertical: RTL and testbench
==============================================

Name: text_pixel_fetcher_vertical

Overview:
- Consumer end of the vertical text pixel generator's toggle interface.
- Drives toggle_restart and toggle_next, and waits the generator's fixed read latency.
- Captures each 8-vertical-pixel byte and presents it, tagged with column/band position, on a valid/ready byte stream.
- Sits between the 16x4 vertical text pixel generator and the display driver (LED matrix page writer); one start yields one full frame of bytes in generator order.

Parameters:
- PIXEL_COLS, 128, pixel columns per band (16 chars x 8).
- PIXEL_BANDS, 8, bands of 8 vertical pixels per frame (4 text rows x 2).
- LATENCY, 4, cycles from a toggle edge to sampling cur_pixels; legal range 3..15.
- COL_SZ, $clog2(PIXEL_COLS), column index width (7).
- BAND_SZ, $clog2(PIXEL_BANDS), band index width (3).

Ports:
- clk  in  1  single clock, shared with the generator.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to fetch one frame; ignored unless idle.
- abort  in  1  synchronous; cancels the frame in progress.
- busy  out  1  high from accepted start until frame end or abort.
- frame_done  out  1  one-cycle pulse after the last byte handshakes.
- toggle_restart  out  1  level; inverted once per frame to restart the generator.
- toggle_next  out  1  level; inverted once per byte advance.
- cur_pixels  in  8  pixel byte from the generator.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts the byte.
- m_data  out  8  captured pixel byte; bit 0 is the top pixel of the band.
- m_col  out  COL_SZ  column of m_data.
- m_band  out  BAND_SZ  band of m_data.
- m_last  out  1  high with the final byte of the frame (col 127, band 7).

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including both toggles, busy, frame_done, m_valid, m_data, m_col, m_band and m_last. Wait counter 0.
- States: IDLE, WAIT, HOLD.
- IDLE + start: invert toggle_restart; set busy=1, col=0, band=0, wait counter=0; go to WAIT.
- IDLE without start: nothing happens. start while busy: ignored, with no queuing.
- WAIT: the counter increments each cycle. When it reaches LATENCY-1, on that edge: m_data<=cur_pixels, m_col/m_band<=current position, m_last<=(col==PIXEL_COLS-1 && band==PIXEL_BANDS-1), m_valid<=1; go to HOLD.
  - Result: the first byte is valid exactly LATENCY cycles after the edge that inverted the toggle.
- HOLD: m_data, m_col, m_band and m_last stay stable while m_valid && !m_ready.
- HOLD on handshake (m_valid && m_ready), not last:
  - m_valid<=0; invert toggle_next.
  - Advance position: col+1; at PIXEL_COLS-1, col wraps to 0 and band+1.
  - Clear the counter; go to WAIT.
- HOLD on handshake, last: m_valid<=0, m_last<=0, busy<=0; pulse frame_done for 1 cycle; go to IDLE. No toggle_next is issued after the last byte.
- Throughput: with m_ready tied high, one byte per LATENCY+1 cycles; 1024 bytes per frame.
- abort (any non-IDLE state): next edge returns to IDLE; m_valid=0, busy=0, m_last=0, no frame_done. Toggles keep their current levels. abort has priority over a same-cycle handshake. abort in IDLE has no effect.
- start and abort in the same IDLE cycle: abort wins; start is ignored.
- Reset mid-frame: everything is cleared as above. The next frame always begins with a restart toggle, which resynchronises the generator regardless of its toggle history.
- Exactly one toggle changes per edge; toggle_restart and toggle_next never invert in the same cycle.
- Counters are sized so that col/band never exceed PIXEL_COLS-1 / PIXEL_BANDS-1.

Test Plan:
- Reset release, start at cycle 5 with m_ready=1 -> toggle_restart flips at edge 5, first m_valid at edge 9 with col=0, band=0, m_data equal to the generator's first byte. Exactly 1024 bytes are produced, the last with col=127, band=7, m_last=1. frame_done pulses once, and toggle_next inverts 1023 times.
- Backpressure: m_ready low for 10 cycles on byte col=5, band=0 -> m_valid held; m_data/m_col/m_band unchanged for all 10 cycles; toggle_next does not change until the handshake.
- Band wrap: after handshake at col=127, band=0 -> next byte reports col=0, band=1, and m_data matches the generator's band-1 column 0.
- start while busy (mid-frame, at byte 300) -> ignored; the frame completes with 1024 bytes, then a new start at IDLE produces a fresh restart toggle.
- abort at byte 40 in HOLD with m_ready=1 in the same cycle -> no handshake counted, m_valid=0, busy=0, no frame_done. A subsequent start yields col=0, band=0 first.
- reset_n asserted asynchronously mid-WAIT -> all outputs 0 immediately. After release, start produces a correct full frame from col=0, band=0.

Source files
------------

// File: rtl/text_pixel_fetcher_vertical.sv
// Consumer side of the vertical text pixel generator's toggle interface.
// Walks one frame in generator order and emits each 8-pixel byte on a valid/ready stream.
module text_pixel_fetcher_vertical #(
  parameter int PIXEL_COLS  = 128,
  parameter int PIXEL_BANDS = 8,
  parameter int LATENCY     = 4,
  parameter int COL_SZ      = $clog2(PIXEL_COLS),
  parameter int BAND_SZ     = $clog2(PIXEL_BANDS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               frame_done,
  output logic               toggle_restart,
  output logic               toggle_next,
  input  logic [7:0]         cur_pixels,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic [COL_SZ-1:0]  m_col,
  output logic [BAND_SZ-1:0] m_band,
  output logic               m_last
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  localparam logic [3:0]         LAST_WAIT = 4'(LATENCY - 1);
  localparam logic [COL_SZ-1:0]  LAST_COL  = COL_SZ'(PIXEL_COLS - 1);
  localparam logic [BAND_SZ-1:0] LAST_BAND = BAND_SZ'(PIXEL_BANDS - 1);

  state_t              state, state_n;
  logic [3:0]          wait_cnt, wait_cnt_n;
  logic [COL_SZ-1:0]   col, col_n;
  logic [BAND_SZ-1:0]  band, band_n;
  logic                busy_n, frame_done_n, toggle_restart_n, toggle_next_n;
  logic                m_valid_n, m_last_n;
  logic [7:0]          m_data_n;
  logic [COL_SZ-1:0]   m_col_n;
  logic [BAND_SZ-1:0]  m_band_n;
  logic                last_pos;

  assign last_pos = (col == LAST_COL) && (band == LAST_BAND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      col            <= '0;
      band           <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      toggle_restart <= 1'b0;
      toggle_next    <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_col          <= '0;
      m_band         <= '0;
      m_last         <= 1'b0;
    end else begin
      state          <= state_n;
      wait_cnt       <= wait_cnt_n;
      col            <= col_n;
      band           <= band_n;
      busy           <= busy_n;
      frame_done     <= frame_done_n;
      toggle_restart <= toggle_restart_n;
      toggle_next    <= toggle_next_n;
      m_valid        <= m_valid_n;
      m_data         <= m_data_n;
      m_col          <= m_col_n;
      m_band         <= m_band_n;
      m_last         <= m_last_n;
    end
  end

  // Abort outranks everything else in a busy state, including a pending handshake.
  always_comb begin
    state_n          = state;
    wait_cnt_n       = wait_cnt;
    col_n            = col;
    band_n           = band;
    busy_n           = busy;
    frame_done_n     = 1'b0;
    toggle_restart_n = toggle_restart;
    toggle_next_n    = toggle_next;
    m_valid_n        = m_valid;
    m_data_n         = m_data;
    m_col_n          = m_col;
    m_band_n         = m_band;
    m_last_n         = m_last;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          toggle_restart_n = ~toggle_restart;
          busy_n           = 1'b1;
          col_n            = '0;
          band_n           = '0;
          wait_cnt_n       = '0;
          state_n          = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_n   = ST_IDLE;
          m_valid_n = 1'b0;
          busy_n    = 1'b0;
          m_last_n  = 1'b0;
        end else if (wait_cnt == LAST_WAIT) begin
          m_data_n  = cur_pixels;
          m_col_n   = col;
          m_band_n  = band;
          m_last_n  = last_pos;
          m_valid_n = 1'b1;
          state_n   = ST_HOLD;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_n   = ST_IDLE;
          m_valid_n = 1'b0;
          busy_n    = 1'b0;
          m_last_n  = 1'b0;
        end else if (m_valid && m_ready) begin
          m_valid_n = 1'b0;
          if (m_last) begin
            m_last_n     = 1'b0;
            busy_n       = 1'b0;
            frame_done_n = 1'b1;
            state_n      = ST_IDLE;
          end else begin
            toggle_next_n = ~toggle_next;
            wait_cnt_n    = '0;
            state_n       = ST_WAIT;
            if (col == LAST_COL) begin
              col_n  = '0;
              band_n = (band == LAST_BAND) ? '0 : band + BAND_SZ'(1);
            end else begin
              col_n = col + COL_SZ'(1);
            end
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_text_pixel_fetcher_vertical.sv
// Directed bench for text_pixel_fetcher_vertical with a small delayed-response generator model.
// Expected bytes come from a closed-form function of the byte position.
module tb_text_pixel_fetcher_vertical;

  localparam int LATENCY = 4;
  localparam int NBYTES  = 1024;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, m_ready;
  logic       busy, frame_done, toggle_restart, toggle_next;
  logic [7:0] cur_pixels;
  logic       m_valid, m_last;
  logic [7:0] m_data;
  logic [6:0] m_col;
  logic [2:0] m_band;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_restart = 1'b0;
  logic exp_next    = 1'b0;

  text_pixel_fetcher_vertical #(.LATENCY(LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done),
    .toggle_restart(toggle_restart), .toggle_next(toggle_next),
    .cur_pixels(cur_pixels), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_col(m_col), .m_band(m_band), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int idx);
    int v;
    v = idx * 29 + (idx / 128) * 101 + 7;
    return v[7:0];
  endfunction

  // Generator model: the new byte reaches cur_pixels three edges after a toggle edge.
  logic       gen_r = 1'b0, gen_n = 1'b0;
  int         gen_idx = 0;
  logic [7:0] gen_stage;
  always @(posedge clk) begin
    if (toggle_restart !== gen_r) gen_idx <= 0;
    else if (toggle_next !== gen_n) gen_idx <= gen_idx + 1;
    gen_r      <= toggle_restart;
    gen_n      <= toggle_next;
    gen_stage  <= pix(gen_idx);
    cur_pixels <= gen_stage;
  end

  logic mon_r = 1'b0, mon_n = 1'b0;
  int next_flips = 0, restart_flips = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (toggle_next !== mon_n) next_flips++;
    if (toggle_restart !== mon_r) restart_flips++;
    if (toggle_next !== mon_n && toggle_restart !== mon_r) both_cnt++;
    mon_n = toggle_next;
    mon_r = toggle_restart;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " m_valid"},    32'(m_valid),    32'd0);
    check({tag, " m_last"},     32'(m_last),     32'd0);
    check({tag, " restart"},    32'(toggle_restart), 32'(exp_restart));
    check({tag, " next"},       32'(toggle_next),    32'(exp_next));
  endtask

  // Runs one frame from IDLE; returns the number of completed handshakes.
  task automatic run_frame(input int abort_at, input int stall_at, input int start_at,
                           output int handshakes);
    int w;
    logic [7:0] d;
    handshakes = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_restart = ~exp_restart;
    check("start restart", 32'(toggle_restart), 32'(exp_restart));
    check("start next",    32'(toggle_next),    32'(exp_next));
    check("start busy",    32'(busy),           32'd1);
    for (int idx = 0; idx < NBYTES; idx++) begin
      w = 0;
      while (!m_valid && w < 20) begin
        tick();
        w++;
      end
      check("valid latency", 32'(w), 32'(LATENCY));
      if (!m_valid) return;
      check("m_col",  32'(m_col),  32'(idx % 128));
      check("m_band", 32'(m_band), 32'(idx / 128));
      check("m_data", 32'(m_data), 32'(pix(idx)));
      check("m_last", 32'(m_last), 32'(idx == NBYTES - 1));
      if (idx == stall_at) begin
        m_ready = 1'b0;
        d = pix(idx);
        repeat (10) begin
          tick();
          check("stall valid", 32'(m_valid),     32'd1);
          check("stall data",  32'(m_data),      32'(d));
          check("stall col",   32'(m_col),       32'(idx % 128));
          check("stall band",  32'(m_band),      32'(idx / 128));
          check("stall next",  32'(toggle_next), 32'(exp_next));
        end
        m_ready = 1'b1;
      end
      if (idx == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        tick();
        check("abort no done", 32'(frame_done), 32'd0);
        return;
      end
      if (idx == start_at) start = 1'b1;
      tick();
      start = 1'b0;
      check("hs valid", 32'(m_valid), 32'd0);
      if (idx == start_at) check("busy start restart", 32'(toggle_restart), 32'(exp_restart));
      handshakes++;
      if (idx == NBYTES - 1) begin
        check("last done",   32'(frame_done),  32'd1);
        check("last busy",   32'(busy),        32'd0);
        check("last m_last", 32'(m_last),      32'd0);
        check("last next",   32'(toggle_next), 32'(exp_next));
        tick();
        check("done pulse", 32'(frame_done), 32'd0);
      end else begin
        exp_next = ~exp_next;
        check("hs next", 32'(toggle_next), 32'(exp_next));
        check("hs busy", 32'(busy),        32'd1);
        check("hs done", 32'(frame_done),  32'd0);
      end
    end
  endtask

  initial begin
    int n, nf0, rf0;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    m_ready = 1'b1;
    #2;
    check_idle_outputs("reset");
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset m_col",  32'(m_col),  32'd0);
    check("reset m_band", 32'(m_band), 32'd0);
    #20 reset_n = 1'b1;
    repeat (4) tick();

    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("idle abort");

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("start+abort");

    nf0 = next_flips;
    rf0 = restart_flips;
    run_frame(-1, 5, 300, n);
    repeat (2) tick();
    check("frameA bytes",    32'(n), 32'(NBYTES));
    check("frameA next",     32'(next_flips - nf0),    32'd1023);
    check("frameA restart",  32'(restart_flips - rf0), 32'd1);
    check_idle_outputs("frameA end");

    run_frame(40, -1, -1, n);
    check("abort handshakes", 32'(n), 32'd40);

    run_frame(-1, -1, -1, n);
    check("frameC bytes", 32'(n), 32'(NBYTES));

    start = 1'b1;
    tick();
    start = 1'b0;
    exp_restart = ~exp_restart;
    tick();
    #2 reset_n = 1'b0;
    #1;
    exp_restart = 1'b0;
    exp_next    = 1'b0;
    check_idle_outputs("async reset");
    check("async reset m_data", 32'(m_data), 32'd0);
    #3 reset_n = 1'b1;
    tick();
    run_frame(-1, -1, -1, n);
    check("frameD bytes", 32'(n), 32'(NBYTES));

    check("toggle overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
